ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the width of every address port.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of every data port.
REQ-003 Parameter MAX_HOLD, default 4, range 1..15, SHALL set the maximum number of consecutive grants to one master while the other requests.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RESET_N  in  1  synchronous active-low reset.
REQ-007 M0_REQ / M1_REQ  in  1  access request; M0 is the CPU data port, M1 is the DMA/loader port.
REQ-008 M0_WE / M1_WE  in  1  1 = write, 0 = read.
REQ-009 M0_ADDR / M1_ADDR  in  ADDR_WIDTH  word address.
REQ-010 M0_WDATA / M1_WDATA  in  DATA_WIDTH  write data.
REQ-011 M0_GNT / M1_GNT  out  1  access accepted this cycle.
REQ-012 M0_RVALID / M1_RVALID  out  1  read data valid.
REQ-013 M0_RDATA / M1_RDATA  out  DATA_WIDTH  read data.
REQ-014 RAM_ADDR  out  ADDR_WIDTH; RAM_WRITE_DATA  out  DATA_WIDTH; RAM_WRITE_ENABLE  out  1; RAM_READ_DATA  in  DATA_WIDTH. These form the single RAM port; the RAM writes on the CLK edge and returns read data one cycle after the address.

Function
REQ-015 State SHALL be OWNER in {IDLE, M0, M1}, LAST (last granted master), and HOLD_CNT (4 bits).
REQ-016 At most one GNT SHALL be high per cycle; GNT is combinational from the REQ inputs and registered state, in the same cycle as REQ.
REQ-017 Only one master requesting: that master SHALL be granted.
REQ-018 Both requesting with OWNER=IDLE: the master not equal to LAST SHALL be granted.
REQ-019 Both requesting with OWNER=Mx: Mx SHALL be granted if HOLD_CNT < MAX_HOLD; otherwise the other master SHALL be granted.
REQ-020 On a grant to the current OWNER, HOLD_CNT SHALL increment, saturating at 15; on a grant to the other master, OWNER SHALL switch and HOLD_CNT SHALL load 1.
REQ-021 On every grant, LAST SHALL be updated to the granted master.
REQ-022 With no REQ, OWNER SHALL go to IDLE, HOLD_CNT SHALL go to 0, and LAST SHALL be held.
REQ-023 With GNT high, RAM_ADDR and RAM_WRITE_DATA SHALL pass the granted master's ADDR and WDATA, and RAM_WRITE_ENABLE SHALL equal the granted master's WE.
REQ-024 With no grant, RAM_ADDR, RAM_WRITE_DATA and RAM_WRITE_ENABLE SHALL all be 0.
REQ-025 Masters SHALL hold REQ, WE, ADDR and WDATA stable until GNT; the arbiter does not buffer requests.
REQ-026 A read granted in cycle N SHALL assert that master's RVALID for exactly cycle N+1; RVALID is a registered tag.
REQ-027 M0_RDATA and M1_RDATA SHALL mirror RAM_READ_DATA at all times and are meaningful only with RVALID.
REQ-028 Writes SHALL never assert RVALID.
REQ-029 Back-to-back grants SHALL be allowed every cycle, giving full throughput.
REQ-030 A read followed by a write to the same address in the next cycle SHALL return the old data.

Reset
REQ-031 RESET_N low at a rising edge SHALL set OWNER=IDLE, HOLD_CNT=0, LAST=M1 (so M0 wins the first tie), and M0_RVALID=M1_RVALID=0.
REQ-032 While RESET_N is low, M0_GNT, M1_GNT and RAM_WRITE_ENABLE SHALL be forced to 0 combinationally, and RAM_ADDR and RAM_WRITE_DATA SHALL be 0.
REQ-033 If reset is sampled at the edge following a read grant, the pending RVALID SHALL NOT assert.

Verification
REQ-034 After reset, M0 writes ADDR=0x005, WDATA=0xDEADBEEF with M1 idle -> M0_GNT=1 in the same cycle, RAM_ADDR=0x005, RAM_WRITE_ENABLE=1, no RVALID next cycle.
REQ-035 M0 reads ADDR=0x003 (RAM holds 0x12345678), granted cycle N -> M0_RVALID=1 and M0_RDATA=0x12345678 at N+1, M1_RVALID=0.
REQ-036 Both masters request reads continuously from reset, MAX_HOLD=4 -> grant sequence M0 x4, M1 x4, M0 x4; each RVALID follows its grant by one cycle.
REQ-037 M1 owns with HOLD_CNT=2 when M0 raises REQ -> M1 gets 2 more grants, then M0 is granted with HOLD_CNT=1.
REQ-038 Owner M0 drops REQ while M1 requests -> M1 is granted that cycle, OWNER=M1, HOLD_CNT=1.
REQ-039 RESET_N driven low for 2 cycles while both request -> both GNT=0 and RAM_WRITE_ENABLE=0 throughout; the first grant after release goes to M0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Master-side request bus for one RAM client of ram_arbiter.
// The master modport is the client's view; the slave modport is the arbiter's view.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM.
// M0 (CPU data port) and M1 (DMA/loader) are granted combinationally in the
// cycle they request. An owner may keep the port for MAX_HOLD consecutive
// grants while the other master waits; ties from idle go to the master that
// was not granted last. Read data returns one cycle after the grant, tagged
// by a registered RVALID.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  ram_arbiter_if.slave          m0,
  ram_arbiter_if.slave          m1,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_WRITE_DATA,
  output logic                  RAM_WRITE_ENABLE,
  input  logic [DATA_WIDTH-1:0] RAM_READ_DATA
);

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_SAT   = 4'hF;

  logic [1:0] owner_q, owner_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       last_q, last_d;
  logic       m0_rvalid_q, m0_rvalid_d;
  logic       m1_rvalid_q, m1_rvalid_d;

  logic       gnt0, gnt1;
  logic [1:0] gnt_owner;

  // Grant decision: single requester wins, ties resolved by owner hold budget or LAST.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RESET_N) begin
      if (m0.req && !m1.req) begin
        gnt0 = 1'b1;
      end else if (!m0.req && m1.req) begin
        gnt1 = 1'b1;
      end else if (m0.req && m1.req) begin
        case (owner_q)
          OWN_M0: begin
            if (hold_cnt_q < MAX_HOLD_C) gnt0 = 1'b1;
            else                         gnt1 = 1'b1;
          end
          OWN_M1: begin
            if (hold_cnt_q < MAX_HOLD_C) gnt1 = 1'b1;
            else                         gnt0 = 1'b1;
          end
          default: begin
            if (last_q == LAST_M1) gnt0 = 1'b1;
            else                   gnt1 = 1'b1;
          end
        endcase
      end
    end
  end

  // Ownership, hold counter and last-granted bookkeeping.
  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    gnt_owner  = gnt1 ? OWN_M1 : OWN_M0;
    if (!m0.req && !m1.req) begin
      owner_d    = OWN_IDLE;
      hold_cnt_d = 4'd0;
    end else if (gnt0 || gnt1) begin
      if (owner_q == gnt_owner) begin
        hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 4'd1;
      end else begin
        owner_d    = gnt_owner;
        hold_cnt_d = 4'd1;
      end
      last_d = gnt1 ? LAST_M1 : LAST_M0;
    end
  end

  // Read tags: a granted read returns data on the following cycle.
  always_comb begin
    m0_rvalid_d = gnt0 && !m0.we;
    m1_rvalid_d = gnt1 && !m1.we;
  end

  // RAM port mux: granted master's request, all zeros when nobody is granted.
  always_comb begin
    RAM_ADDR         = '0;
    RAM_WRITE_DATA   = '0;
    RAM_WRITE_ENABLE = 1'b0;
    if (gnt0) begin
      RAM_ADDR         = m0.addr;
      RAM_WRITE_DATA   = m0.wdata;
      RAM_WRITE_ENABLE = m0.we;
    end else if (gnt1) begin
      RAM_ADDR         = m1.addr;
      RAM_WRITE_DATA   = m1.wdata;
      RAM_WRITE_ENABLE = m1.we;
    end
  end

  // State registers with synchronous reset; a reset edge also drops a pending read tag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      owner_q     <= OWN_IDLE;
      hold_cnt_q  <= 4'd0;
      last_q      <= LAST_M1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = m0_rvalid_q;
  assign m1.rvalid = m1_rvalid_q;
  assign m0.rdata  = RAM_READ_DATA;
  assign m1.rdata  = RAM_READ_DATA;

endmodule
